// File: rtl/axis_lane_merger.sv
// rtl/axis_lane_merger.sv - merges KERNEL_SIZE per-lane AXI-Stream inputs into one wide beat
// Each lane has its own FIFO; a wide beat pops from all lanes at once, only when none is empty.
module axis_lane_merger #(
  parameter int KERNEL_SIZE = 3,
  parameter int DATA_WIDTH  = 8,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [KERNEL_SIZE*DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [KERNEL_SIZE-1:0]              s_axis_tvalid,
  output logic [KERNEL_SIZE-1:0]              s_axis_tready,
  output logic [KERNEL_SIZE*DATA_WIDTH-1:0]   m_axis_tdata,
  output logic                                m_axis_tvalid,
  input  logic                                m_axis_tready,
  output logic [KERNEL_SIZE-1:0]              lane_empty,
  output logic [KERNEL_SIZE-1:0]              lane_full
);

  localparam int FULL_WIDTH = KERNEL_SIZE * DATA_WIDTH;
  localparam int CW         = $clog2(FIFO_DEPTH + 1);
  localparam int PW         = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  logic [DATA_WIDTH-1:0] mem_q    [KERNEL_SIZE][FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] mem_d    [KERNEL_SIZE][FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr_q [KERNEL_SIZE];
  logic [PW-1:0]         wr_ptr_d [KERNEL_SIZE];
  logic [PW-1:0]         rd_ptr_q [KERNEL_SIZE];
  logic [PW-1:0]         rd_ptr_d [KERNEL_SIZE];
  logic [CW-1:0]         count_q  [KERNEL_SIZE];
  logic [CW-1:0]         count_d  [KERNEL_SIZE];

  logic [KERNEL_SIZE-1:0] not_empty;
  logic [KERNEL_SIZE-1:0] full_raw;
  logic [KERNEL_SIZE-1:0] push;
  logic                   pop;

  always_comb begin
    for (int i = 0; i < KERNEL_SIZE; i++) begin
      not_empty[i] = (count_q[i] != '0);
      full_raw[i]  = (count_q[i] == CW'(FIFO_DEPTH));
    end
  end

  // Pop is decided from registered counts only, so a full lane can never push and pop together.
  always_comb begin
    pop      = (&not_empty) && m_axis_tready && !rst;
    push     = '0;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    for (int i = 0; i < KERNEL_SIZE; i++) begin
      push[i] = s_axis_tvalid[i] && !full_raw[i] && !rst;
      if (push[i]) begin
        mem_d[i][wr_ptr_q[i]] = s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
        wr_ptr_d[i]           = wr_ptr_q[i] + PW'(1);
      end
      if (pop) begin
        rd_ptr_d[i] = rd_ptr_q[i] + PW'(1);
      end
      count_d[i] = count_q[i] + CW'(push[i]) - CW'(pop);
      if (rst) begin
        wr_ptr_d[i] = '0;
        rd_ptr_d[i] = '0;
        count_d[i]  = '0;
        for (int j = 0; j < FIFO_DEPTH; j++) begin
          mem_d[i][j] = '0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    mem_q    <= mem_d;
    wr_ptr_q <= wr_ptr_d;
    rd_ptr_q <= rd_ptr_d;
    count_q  <= count_d;
  end

  always_comb begin
    s_axis_tready = ~full_raw & {KERNEL_SIZE{!rst}};
    lane_full     = full_raw & {KERNEL_SIZE{!rst}};
    lane_empty    = ~not_empty | {KERNEL_SIZE{rst}};
    m_axis_tvalid = (&not_empty) && !rst;
    m_axis_tdata  = '0;
    for (int i = 0; i < KERNEL_SIZE; i++) begin
      m_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH] = rst ? '0 : mem_q[i][rd_ptr_q[i]];
    end
  end

endmodule

// File: doc/axis_lane_merger.md
Name: axis_lane_merger

Overview:
- Inverse of the lane splitter: gathers KERNEL_SIZE independent per-lane AXI-Stream inputs, each DATA_WIDTH wide with its own tvalid/tready, into one wide AXI-Stream output beat of KERNEL_SIZE*DATA_WIDTH bits.
- Each lane has its own FIFO of depth FIFO_DEPTH, which absorbs skew between lanes.
- A wide beat is emitted only when every lane holds at least one word.
- Sits downstream of per-lane kernel processing and re-forms the packed word for the next stage.

Parameters:
- KERNEL_SIZE, 3, number of lanes.
- DATA_WIDTH, 8, bits per lane word.
- FIFO_DEPTH, 4, words per lane FIFO; must be a power of two and at least 2.
- Derived (localparam): FULL_WIDTH = KERNEL_SIZE*DATA_WIDTH.
- Derived (localparam): CW = $clog2(FIFO_DEPTH+1).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous reset, active-high.
- s_axis_tdata  in  FULL_WIDTH  lane i word at bits [i*DATA_WIDTH +: DATA_WIDTH].
- s_axis_tvalid  in  KERNEL_SIZE  per-lane valid.
- s_axis_tready  out  KERNEL_SIZE  per-lane ready.
- m_axis_tdata  out  FULL_WIDTH  merged word; lane i at bits [i*DATA_WIDTH +: DATA_WIDTH].
- m_axis_tvalid  out  1  merged beat valid.
- m_axis_tready  in  1  downstream ready.
- lane_empty  out  KERNEL_SIZE  per-lane FIFO empty flag.
- lane_full  out  KERNEL_SIZE  per-lane FIFO full flag.

Behaviour:
- Per-lane FIFO: circular buffer with write pointer, read pointer and count (CW bits).
  - Pointers wrap modulo FIFO_DEPTH.
  - Count ranges 0..FIFO_DEPTH.
- Reset (rst=1 at a clock edge):
  - All pointers and counts go to 0.
  - lane_empty=all 1s, lane_full=0, s_axis_tready=0 during the reset cycle, m_axis_tvalid=0, m_axis_tdata=0.
  - Reset mid-operation discards all buffered words; no beat is emitted afterwards until new words arrive.
- s_axis_tready[i] = !lane_full[i] and !rst.
  - Depends only on registered state; never on s_axis_tvalid.
- Lane push: occurs on a clock edge when s_axis_tvalid[i] && s_axis_tready[i].
  - The word is written at the lane's write pointer, then the write pointer is incremented.
- m_axis_tvalid = AND of !lane_empty[i] over all lanes.
  - Derived from registered counts only; never from m_axis_tready.
- m_axis_tdata is first-word-fall-through: it is the concatenation of each lane's word at its read pointer.
  - Must be registered or a direct memory read of registered pointers; no combinational path from s_axis inputs.
- Pop: occurs on an edge when m_axis_tvalid && m_axis_tready.
  - All lanes pop together; every read pointer increments.
- Partial data never pops: if any lane is empty, m_axis_tvalid=0, and m_axis_tready is ignored for every lane.
- Latency: a word pushed at edge N that completes the set makes m_axis_tvalid=1 in the cycle after edge N (1 cycle).
- Simultaneous push and pop on the same lane:
  - Allowed only when the lane is not full; count is unchanged, both pointers advance.
  - A full lane does not accept a push in the same cycle as a pop; its ready rises the cycle after the pop.
- Backpressure: m_axis_tdata and m_axis_tvalid hold stable while m_axis_tvalid=1 and m_axis_tready=0.
- Skew: a fast lane fills to FIFO_DEPTH and stalls (ready=0) independently; other lanes keep accepting.
- Flags: lane_full[i] = (count==FIFO_DEPTH); lane_empty[i] = (count==0).
  - Both track the count with the same timing as the ready signals.
- Throughput: one merged beat per cycle when all lanes are streaming and downstream is ready.

Test Plan:
- Reset then push one word per lane in the same cycle: lane0=CC, lane1=BB, lane2=AA; m_axis_tready=1 -> m_axis_tvalid=1 the next cycle with m_axis_tdata=24'hAABBCC, then 0 the following cycle.
- Skewed arrival: lane0 gets 33 at cycle 0, lane1 gets 22 at cycle 3, lane2 gets 11 at cycle 6 -> m_axis_tvalid stays 0 until cycle 7, then shows 24'h112233.
- Fill with m_axis_tready=0: push 4 words per lane (AABBCC, 112233, DDEEFF, 445566) -> s_axis_tready=3'b000 and lane_full=3'b111; a 5th word 778899 is held. Pulse m_axis_tready for one cycle -> 24'hAABBCC is consumed, ready returns, and 778899 enters. Drain -> output order 112233, DDEEFF, 445566, 778899, then m_axis_tvalid=0 and lane_empty=3'b111.
- One lane starved: push 4 words into lanes 0 and 1, none into lane 2, m_axis_tready=1 -> m_axis_tvalid=0 throughout, lane_full=3'b011, s_axis_tready=3'b100, nothing popped.
- Streaming: all lanes valid every cycle with an incrementing pattern, m_axis_tready=1 -> one beat per cycle, no drops, no duplicates, count never exceeds 1.
- Reset mid-operation: with 2 words buffered per lane, assert rst for one cycle -> m_axis_tvalid=0, lane_empty=3'b111; after release, new word 010203 is output as the first beat.
